// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, redirect targets, instruction memory
// port and the IF/ID register outputs. The fetch stage is the master side.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic [1:0]       pcsrc;
    logic [WIDTH-1:0] pc_target;
    logic [WIDTH-1:0] jalr_target;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] pc_f;
    logic [WIDTH-1:0] instr_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4_d;
    logic             valid_d;
    logic             misalign_err;
    logic [WIDTH-1:0] fetch_count;

    modport master (
        input  stall_f, stall_d, flush_d, pcsrc, pc_target, jalr_target, imem_rdata,
        output imem_addr, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_err, fetch_count
    );

    modport slave (
        output stall_f, stall_d, flush_d, pcsrc, pc_target, jalr_target, imem_rdata,
        input  imem_addr, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, next-PC select, and the IF/ID
// pipeline register with stall/flush. Also keeps a sticky misaligned-target
// flag and a count of instructions handed to decode.
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic [WIDTH-1:0] instr_q, pc_d_q, pc_plus4_d_q, count_q;
    logic             valid_q, misalign_q;

    assign pc_plus4 = pc_q + WIDTH'(4);

    // Redirect decode: 01 branch/JAL, 10 JALR with LSB forced low; 00/11 sequential.
    always_comb begin
        redirect = 1'b0;
        target   = pc_plus4;
        case (bus.pcsrc)
            2'b01: begin
                redirect = 1'b1;
                target   = bus.pc_target;
            end
            2'b10: begin
                redirect = 1'b1;
                target   = {bus.jalr_target[WIDTH-1:1], 1'b0};
            end
            default: begin
                redirect = 1'b0;
                target   = pc_plus4;
            end
        endcase
    end

    // PC register: a redirect comes from an older instruction, so it wins over stall_f.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_PC;
        else if (redirect)
            pc_q <= target;
        else if (!bus.stall_f)
            pc_q <= pc_plus4;
    end

    // IF/ID register: flush inserts a bubble even while decode is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q      <= NOP;
            pc_d_q       <= '0;
            pc_plus4_d_q <= '0;
            valid_q      <= 1'b0;
            count_q      <= '0;
        end else if (bus.flush_d) begin
            instr_q      <= NOP;
            pc_d_q       <= '0;
            pc_plus4_d_q <= '0;
            valid_q      <= 1'b0;
        end else if (!bus.stall_d) begin
            instr_q      <= bus.imem_rdata;
            pc_d_q       <= pc_q;
            pc_plus4_d_q <= pc_plus4;
            valid_q      <= 1'b1;
            count_q      <= count_q + WIDTH'(1);
        end
    end

    // Sticky flag for any redirect landing off a word boundary; the PC still follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (redirect && (target[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc_f         = pc_q;
    assign bus.instr_d      = instr_q;
    assign bus.pc_d         = pc_d_q;
    assign bus.pc_plus4_d   = pc_plus4_d_q;
    assign bus.valid_d      = valid_q;
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan scenarios followed
// by random hazard/redirect traffic, all compared against a cycle model.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_stage_if #(.WIDTH(32)) bus ();

    fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: test-plan program at 0..C, address-derived words elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h0000_0013;
            default: return {a[15:0], 16'h0000} ^ 32'h1234_5677 ^ {16'h0, a[31:16]};
        endcase
    endfunction

    always_comb bus.imem_rdata = imem(bus.imem_addr);

    // Reference state: what the stage should hold after each edge.
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
    logic        m_valid, m_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = NOP; m_pcd = 0; m_pcp4 = 0;
        m_valid = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_f"},   bus.pc_f,         m_pc);
        chk({tag, ".iaddr"},  bus.imem_addr,    m_pc);
        chk({tag, ".instr"},  bus.instr_d,      m_instr);
        chk({tag, ".pc_d"},   bus.pc_d,         m_pcd);
        chk({tag, ".pcp4"},   bus.pc_plus4_d,   m_pcp4);
        chk({tag, ".valid"},  32'(bus.valid_d), 32'(m_valid));
        chk({tag, ".mis"},    32'(bus.misalign_err), 32'(m_mis));
        chk({tag, ".count"},  bus.fetch_count,  m_cnt);
    endtask

    // Apply current inputs across one rising edge, advance the model, check 1ns later.
    task automatic step(input string tag);
        logic [31:0] fetched, dest;
        logic        jump;
        fetched = imem(m_pc);
        jump    = (bus.pcsrc == 2'd1) || (bus.pcsrc == 2'd2);
        dest    = (bus.pcsrc == 2'd1) ? bus.pc_target : (bus.jalr_target & ~32'd1);
        @(posedge clk);
        #1;
        if (bus.flush_d) begin
            m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
        end else if (!bus.stall_d) begin
            m_instr = fetched; m_pcd = m_pc; m_pcp4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
        end
        if (jump) begin
            if (dest % 4 != 0) m_mis = 1;
            m_pc = dest;
        end else if (!bus.stall_f) begin
            m_pc = m_pc + 4;
        end
        check_all(tag);
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fl, input logic [1:0] src,
                         input logic [31:0] tgt, input logic [31:0] jt);
        bus.stall_f = sf; bus.stall_d = sd; bus.flush_d = fl;
        bus.pcsrc = src; bus.pc_target = tgt; bus.jalr_target = jt;
    endtask

    initial begin
        drive(0, 0, 0, 2'd0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Free run through the four-instruction program.
        for (int i = 0; i < 4; i++) step("seq");
        chk("seq.fc4", bus.fetch_count, 32'd4);
        chk("seq.pc10", bus.pc_f, 32'h10);

        // Stall both stages two cycles at 0x10, then resume.
        drive(1, 1, 0, 2'd0, 0, 0);
        step("stall1");
        step("stall2");
        chk("stall.pc", bus.pc_f, 32'h10);
        drive(0, 0, 0, 2'd0, 0, 0);
        step("resume");
        chk("resume.pc", bus.pc_f, 32'h14);

        // Taken branch with flush.
        drive(0, 0, 1, 2'd1, 32'h40, 0);
        step("br");
        chk("br.pc", bus.pc_f, 32'h40);
        drive(0, 0, 0, 2'd0, 0, 0);
        step("br2");
        chk("br2.pc_d", bus.pc_d, 32'h40);
        chk("br2.instr", bus.instr_d, imem(32'h40));

        // JALR: odd target is word-aligned after LSB clear; 0x102 is misaligned.
        drive(0, 0, 1, 2'd2, 0, 32'h101);
        step("jalr1");
        chk("jalr1.pc", bus.pc_f, 32'h100);
        chk("jalr1.mis", 32'(bus.misalign_err), 32'd0);
        drive(0, 0, 1, 2'd2, 0, 32'h102);
        step("jalr2");
        chk("jalr2.mis", 32'(bus.misalign_err), 32'd1);
        drive(0, 0, 0, 2'd0, 0, 0);
        step("jalr3");

        // Redirect and flush override both stalls.
        drive(1, 1, 1, 2'd1, 32'h80, 0);
        step("simul");
        chk("simul.pc", bus.pc_f, 32'h80);
        chk("simul.valid", 32'(bus.valid_d), 32'd0);

        // Walk to 0x24 then assert reset between edges.
        drive(0, 0, 1, 2'd1, 32'h20, 0);
        step("to20");
        drive(0, 0, 0, 2'd0, 0, 0);
        step("to24");
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst.pc", bus.pc_f, RESET_PC);
        chk("arst.valid", 32'(bus.valid_d), 32'd0);
        chk("arst.count", bus.fetch_count, 32'd0);
        chk("arst.mis", 32'(bus.misalign_err), 32'd0);
        @(posedge clk);
        #1;
        check_all("arst.hold");
        rst = 1'b0;

        // Reserved pcsrc is sequential and never flags misalignment.
        drive(0, 0, 0, 2'd3, 32'h3, 32'h3);
        step("rsv");
        chk("rsv.pc", bus.pc_f, 32'h4);

        // PC wrap.
        drive(0, 0, 1, 2'd1, 32'hFFFF_FFFC, 0);
        step("wrap0");
        drive(0, 0, 0, 2'd0, 0, 0);
        step("wrap1");
        chk("wrap.pc", bus.pc_f, 32'h0);
        chk("wrap.pcp4", bus.pc_plus4_d, 32'h0);

        // Random traffic; misaligned targets are rare so the sticky flag shows up late.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  src;
            logic [31:0] t, j;
            src = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) src = 2'd0;
            t = $urandom & 32'hFFFF_FFFC;
            j = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 40) == 0) t = t | 32'h2;
            if ($urandom_range(0, 40) == 0) j = j | 32'h2;
            drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), src, t, j);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
